// File: rtl/reg_file_mp.sv
// Multi-port register file with byte-lane writes, same-cycle write forwarding,
// a per-register busy scoreboard and a DEPTH-cycle bulk clear sequence.
module reg_file_mp #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    input  logic [NB-1:0]     WrByteEn,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  RdDataA,
    output logic [WIDTH-1:0]  RdDataB,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              BusyA,
    output logic              BusyB,
    input  logic              ClrStart,
    output logic              ClrBusy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic               clr_busy_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [WIDTH-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]   busy_q;

    logic               idle;
    logic               wr_ok;
    logic               iss_ok;
    logic [WIDTH-1:0]   wr_merged;
    logic               fwd_a, fwd_b;

    function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_d,
                                                    input logic [WIDTH-1:0] new_d,
                                                    input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old_d;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle      = (state_q == IDLE);
    assign wr_ok     = WrEn && idle && !is_zero_reg(WrAddr);
    assign iss_ok    = IssueEn && idle && !is_zero_reg(IssueAddr);
    assign wr_merged = byte_merge(regs_q[WrAddr], WrData, WrByteEn);

    // Forwarding only applies to writes that will actually land this edge.
    assign fwd_a = (BYPASS != 0) && wr_ok && (WrAddr == RdAddrA);
    assign fwd_b = (BYPASS != 0) && wr_ok && (WrAddr == RdAddrB);

    always_comb begin
        RdDataA = regs_q[RdAddrA];
        if (is_zero_reg(RdAddrA)) RdDataA = '0;
        else if (fwd_a)           RdDataA = wr_merged;
    end

    always_comb begin
        RdDataB = regs_q[RdAddrB];
        if (is_zero_reg(RdAddrB)) RdDataB = '0;
        else if (fwd_b)           RdDataB = wr_merged;
    end

    assign BusyA   = busy_q[RdAddrA] & ~fwd_a;
    assign BusyB   = busy_q[RdAddrB] & ~fwd_b;
    assign ClrBusy = clr_busy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ClrStart) state_d = CLEAR;
            CLEAR:   if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_busy_q <= (state_d == CLEAR);
            cnt_q      <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            regs_q[WrAddr] <= wr_merged;
        end
    end

    // Issue is applied after the write clear so a same-address issue wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy_q <= '0;
        end else if (state_q == CLEAR) begin
            busy_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_ok)  busy_q[WrAddr]    <= 1'b0;
            if (iss_ok) busy_q[IssueAddr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: vector table for read/write/scoreboard
// behaviour plus hand sequences for forwarding, bulk clear and mid-clear reset.
module tb_reg_file_mp;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic [3:0]  WrByteEn;
    logic [4:0]  RdAddrA, RdAddrB;
    logic [31:0] RdDataA, RdDataB, nb_RdDataA, nb_RdDataB;
    logic        IssueEn;
    logic [4:0]  IssueAddr;
    logic        BusyA, BusyB, nb_BusyA, nb_BusyB;
    logic        ClrStart;
    logic        ClrBusy, nb_ClrBusy;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    reg_file_mp dut (
        .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .RdDataA(RdDataA), .RdDataB(RdDataB), .IssueEn(IssueEn), .IssueAddr(IssueAddr),
        .BusyA(BusyA), .BusyB(BusyB), .ClrStart(ClrStart), .ClrBusy(ClrBusy)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .RdDataA(nb_RdDataA), .RdDataB(nb_RdDataB), .IssueEn(IssueEn), .IssueAddr(IssueAddr),
        .BusyA(nb_BusyA), .BusyB(nb_BusyB), .ClrStart(ClrStart), .ClrBusy(nb_ClrBusy)
    );

    typedef struct {
        logic        wren;
        logic [4:0]  wra;
        logic [31:0] wrd;
        logic [3:0]  be;
        logic        iss;
        logic [4:0]  isa;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic wren, input logic [4:0] wra, input logic [31:0] wrd,
                                input logic [3:0] be, input logic iss, input logic [4:0] isa,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic eba, input logic ebb);
        vec_t v;
        v.wren = wren; v.wra = wra; v.wrd = wrd; v.be = be; v.iss = iss; v.isa = isa;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        WrEn = 1'b0; WrAddr = '0; WrData = '0; WrByteEn = '0;
        IssueEn = 1'b0; IssueAddr = '0; ClrStart = 1'b0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int n;
        Reset = 1'b0;
        RdAddrA = '0; RdAddrB = '0;
        idle_inputs();

        vt[0]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 0,  5,  32'h0,        32'h0,        0, 0);
        vt[1]  = mk(1, 5,  32'hAABBCCDD, 4'hF, 0, 0, 5,  1,  32'hAABBCCDD, 32'h0,        0, 0);
        vt[2]  = mk(1, 5,  32'h11223344, 4'h5, 0, 0, 5,  6,  32'hAA22CC44, 32'h0,        0, 0);
        vt[3]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 5,  7,  32'hAA22CC44, 32'hDEADBEEF, 0, 0);
        vt[4]  = mk(1, 11, 32'hCAFEF00D, 4'hF, 0, 0, 11, 11, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
        vt[5]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 11, 5,  32'hCAFEF00D, 32'hAA22CC44, 0, 0);
        vt[6]  = mk(1, 0,  32'hFFFFFFFF, 4'hF, 1, 0, 0,  0,  32'h0,        32'h0,        0, 0);
        vt[7]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0);
        vt[8]  = mk(0, 0,  32'h0,        4'h0, 1, 3, 3,  0,  32'h0,        32'h0,        0, 0);
        vt[9]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 3,  3,  32'h0,        32'h0,        1, 1);
        vt[10] = mk(1, 3,  32'h12345678, 4'hF, 1, 3, 4,  0,  32'h0,        32'h0,        0, 0);
        vt[11] = mk(0, 0,  32'h0,        4'h0, 0, 0, 3,  3,  32'h12345678, 32'h12345678, 1, 1);
        vt[12] = mk(1, 3,  32'h0,        4'h0, 0, 0, 3,  3,  32'h12345678, 32'h12345678, 0, 0);
        vt[13] = mk(0, 0,  32'h0,        4'h0, 0, 0, 3,  3,  32'h12345678, 32'h12345678, 0, 0);
        vt[14] = mk(0, 0,  32'h0,        4'h0, 1, 9, 9,  9,  32'h0,        32'h0,        0, 0);
        vt[15] = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  9,  32'h0,        32'h0,        1, 1);
        vt[16] = mk(1, 9,  32'h000000AB, 4'h1, 0, 0, 1,  9,  32'h0,        32'h000000AB, 0, 0);
        vt[17] = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  2,  32'h000000AB, 32'h0,        0, 0);

        // Reset state
        repeat (2) @(posedge Clock);
        for (int i = 0; i < 32; i += 8) begin
            @(negedge Clock);
            RdAddrA = 5'(i + 3); RdAddrB = 5'(31 - i);
            #1;
            chk($sformatf("rst rda%0d", i + 3), RdDataA, 32'h0);
            chk($sformatf("rst rdb%0d", 31 - i), RdDataB, 32'h0);
            chk1("rst busyA", BusyA, 1'b0);
            chk1("rst clrbusy", ClrBusy, 1'b0);
        end
        @(negedge Clock);
        Reset = 1'b1;
        step();

        // Forwarding vs non-forwarding instance on reg 7
        WrEn = 1'b1; WrAddr = 7; WrData = 32'hDEADBEEF; WrByteEn = 4'hF; RdAddrA = 7;
        @(negedge Clock);
        chk("fwd bypass rda", RdDataA, 32'hDEADBEEF);
        chk("fwd nobypass rda", nb_RdDataA, 32'h0);
        step();
        idle_inputs();
        @(negedge Clock);
        chk("fwd bypass rda next", RdDataA, 32'hDEADBEEF);
        chk("fwd nobypass rda next", nb_RdDataA, 32'hDEADBEEF);
        step();

        // Vector table
        for (int i = 0; i < 18; i++) begin
            WrEn = vt[i].wren; WrAddr = vt[i].wra; WrData = vt[i].wrd; WrByteEn = vt[i].be;
            IssueEn = vt[i].iss; IssueAddr = vt[i].isa;
            RdAddrA = vt[i].ra; RdAddrB = vt[i].rb;
            @(negedge Clock);
            chk($sformatf("vec%0d rda", i), RdDataA, vt[i].ea);
            chk($sformatf("vec%0d rdb", i), RdDataB, vt[i].eb);
            chk1($sformatf("vec%0d busyA", i), BusyA, vt[i].eba);
            chk1($sformatf("vec%0d busyB", i), BusyB, vt[i].ebb);
            step();
            idle_inputs();
        end

        // Fill every register and set every busy bit
        for (int i = 0; i < 32; i++) begin
            WrEn = 1'b1; WrAddr = 5'(i); WrData = 32'hA5000000 | 32'(i) | 32'h100; WrByteEn = 4'hF;
            IssueEn = 1'b1; IssueAddr = 5'(i);
            step();
        end
        idle_inputs();
        RdAddrA = 17; RdAddrB = 31;
        @(negedge Clock);
        chk("fill rda17", RdDataA, 32'hA5000111);
        chk("fill rdb31", RdDataB, 32'hA500011F);
        chk1("fill busyA17", BusyA, 1'b1);
        chk1("fill busyB31", BusyB, 1'b1);
        step();

        // Full clear; a write/issue in the middle must be ignored
        ClrStart = 1'b1;
        step();
        idle_inputs();
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clock);
            if (!ClrBusy) break;
            n++;
            if (n == 5) begin
                WrEn = 1'b1; WrAddr = 2; WrData = 32'hFFFFFFFF; WrByteEn = 4'hF;
                IssueEn = 1'b1; IssueAddr = 2;
            end
            step();
            idle_inputs();
        end
        chk("clear cycles", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            @(negedge Clock);
            RdAddrA = 5'(i); RdAddrB = 5'(31 - i);
            #1;
            chk($sformatf("clr rda%0d", i), RdDataA, 32'h0);
            chk1($sformatf("clr busyA%0d", i), BusyA, 1'b0);
            chk1($sformatf("clr busyB%0d", 31 - i), BusyB, 1'b0);
        end
        step();

        // ClrStart with a same-edge write/issue, then reset at clear cycle 10
        WrEn = 1'b1; WrAddr = 20; WrData = 32'h00002020; WrByteEn = 4'hF;
        IssueEn = 1'b1; IssueAddr = 20; ClrStart = 1'b1;
        RdAddrA = 20; RdAddrB = 20;
        step();
        idle_inputs();
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clock);
            if (!ClrBusy) break;
            n++;
            if (n == 1) begin
                chk("clr2 start rda20", RdDataA, 32'h00002020);
                chk1("clr2 start busyA20", BusyA, 1'b1);
            end
            if (n == 10) break;
            step();
        end
        chk("clr2 reached cycle 10", 32'(n), 32'd10);
        chk("clr2 partial rdb20", RdDataB, 32'h00002020);
        #2;
        Reset = 1'b0;
        #1;
        chk1("midclr reset clrbusy", ClrBusy, 1'b0);
        chk("midclr reset rda20", RdDataA, 32'h0);
        chk1("midclr reset busyA20", BusyA, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        step();
        WrEn = 1'b1; WrAddr = 6; WrData = 32'h00000066; WrByteEn = 4'hF;
        step();
        idle_inputs();
        RdAddrA = 6;
        @(negedge Clock);
        chk("post reset write rda6", RdDataA, 32'h00000066);
        chk1("post reset clrbusy", ClrBusy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
